// File: rtl/gather_pkg.sv
// gather_pkg: shared constants, state encoding and permutation check helper for gather_by_pointer.
package gather_pkg;
  localparam int N_ELEM = 9;
  localparam int ELEM_W = 8;
  localparam int PTR_W = 4;
  localparam logic [PTR_W-1:0] PTR_NONE = '1;
  typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;
  // Flags any out-of-range pointer or any index referenced twice.
  function automatic logic perm_bad(input logic [N_ELEM*PTR_W-1:0] ptrs);
    logic [N_ELEM-1:0] used;
    logic bad;
    logic [PTR_W-1:0] p;
    used = '0;
    bad = 1'b0;
    for (int k = 0; k < N_ELEM; k++) begin
      p = ptrs[k*PTR_W +: PTR_W];
      if (p >= PTR_W'(N_ELEM)) bad = 1'b1;
      else begin
        if (used[p]) bad = 1'b1;
        used[p] = 1'b1;
      end
    end
    return bad;
  endfunction
endpackage

// File: rtl/gather_by_pointer_if.sv
// gather_by_pointer_if: frame input and element stream bundle; perm_err exists only with GATHER_PERM_CHECK_EN.
interface gather_by_pointer_if;
  import gather_pkg::*;
  logic in_valid;
  logic in_ready;
  logic [N_ELEM*ELEM_W-1:0] arr_flat;
  logic [N_ELEM*PTR_W-1:0] ptr_flat;
  logic abort;
  logic out_valid;
  logic out_ready;
  logic [ELEM_W-1:0] out_data;
  logic [PTR_W-1:0] out_idx;
  logic out_last;
  logic out_err;
  logic frame_err;
  logic done;
`ifdef GATHER_PERM_CHECK_EN
  logic perm_err;
  modport master(output in_valid, arr_flat, ptr_flat, abort, out_ready,
                 input in_ready, out_valid, out_data, out_idx, out_last, out_err, frame_err, done, perm_err);
  modport slave(input in_valid, arr_flat, ptr_flat, abort, out_ready,
                output in_ready, out_valid, out_data, out_idx, out_last, out_err, frame_err, done, perm_err);
`else
  modport master(output in_valid, arr_flat, ptr_flat, abort, out_ready,
                 input in_ready, out_valid, out_data, out_idx, out_last, out_err, frame_err, done);
  modport slave(input in_valid, arr_flat, ptr_flat, abort, out_ready,
                output in_ready, out_valid, out_data, out_idx, out_last, out_err, frame_err, done);
`endif
endinterface

// File: rtl/gather_mux.sv
// gather_mux: N:1 element select with range check; out-of-range pointers yield zero data and err.
module gather_mux #(
  parameter int N = 9,
  parameter int W = 8,
  parameter int PW = 4
) (
  input  logic [N-1:0][W-1:0] arr,
  input  logic [PW-1:0]       ptr,
  output logic [W-1:0]        data,
  output logic                err
);
  assign err = ptr >= PW'(N);
  assign data = err ? '0 : arr[ptr];
endmodule

// File: rtl/gather_by_pointer.sv
// gather_by_pointer: streams arr[ptr_k] for k = 0..N-1 from a registered frame.
// Define GATHER_PERM_CHECK_EN to add perm_err (duplicate or out-of-range pointer in the frame).
module gather_by_pointer
  import gather_pkg::*;
(
  input logic clk,
  input logic rst_n,
  gather_by_pointer_if.slave bus
);
  state_t state, state_nx;
  logic [N_ELEM-1:0][ELEM_W-1:0] arr_q;
  logic [N_ELEM-1:0][PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] idx;
  logic [ELEM_W-1:0] data;
  logic err, emit, last, in_ready, accept, beat, frame_err;
  gather_mux #(.N(N_ELEM), .W(ELEM_W), .PW(PTR_W)) u_mux (
    .arr(arr_q), .ptr(ptr_q[idx]), .data(data), .err(err)
  );
  assign emit = state == EMIT;
  assign last = idx == PTR_W'(N_ELEM - 1);
  // rst_n gating keeps in_ready low while reset is held.
  assign in_ready = state == IDLE && rst_n;
  assign accept = in_ready && bus.in_valid && !bus.abort;
  assign beat = emit && bus.out_ready && !bus.abort;
  always_comb begin
    state_nx = bus.abort ? IDLE :
               accept ? EMIT :
               (beat && last) ? DONE :
               state == DONE ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      arr_q <= '0;
      ptr_q <= '0;
      idx <= '0;
      frame_err <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        arr_q <= bus.arr_flat;
        ptr_q <= bus.ptr_flat;
        idx <= '0;
        frame_err <= 1'b0;
      end else if (beat) begin
        frame_err <= frame_err | err;
        if (!last) idx <= idx + 1'b1;
      end
    end
  end
`ifdef GATHER_PERM_CHECK_EN
  logic perm_err;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) perm_err <= 1'b0;
    else if (accept) perm_err <= perm_bad(bus.ptr_flat);
  end
  assign bus.perm_err = perm_err;
`endif
  assign bus.in_ready = in_ready;
  assign bus.out_valid = emit;
  assign bus.out_data = emit ? data : '0;
  assign bus.out_idx = idx;
  assign bus.out_last = emit && last;
  assign bus.out_err = emit && err;
  assign bus.frame_err = frame_err;
  assign bus.done = state == DONE;
endmodule

// File: tb/tb_gather_by_pointer.sv
// tb_gather_by_pointer: table-driven frames plus back-pressure, abort and reset sequences.
module tb_gather_by_pointer;
  import gather_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  gather_by_pointer_if bus();
  gather_by_pointer dut(.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    int arr[9];
    int ptr[9];
    int exp[9];
    logic [8:0] err;
    logic perm;
  } vec_t;
  vec_t vecs[5];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, act, want, $time);
    end
  endtask
  task automatic load(input int v);
    for (int i = 0; i < 9; i++) begin
      bus.arr_flat[i*ELEM_W +: ELEM_W] = ELEM_W'(vecs[v].arr[i]);
      bus.ptr_flat[i*PTR_W +: PTR_W] = vecs[v].ptr[i] == 15 ? PTR_NONE : PTR_W'(vecs[v].ptr[i]);
    end
  endtask
  task automatic do_frame(input int v, input bit bp);
    int beat, c;
    logic fe;
    @(negedge clk);
    chk("in_ready_idle", 32'(bus.in_ready), 1);
    load(v);
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    beat = 0;
    c = 0;
    fe = 1'b0;
    while (c < 60) begin
      @(negedge clk);
      chk("out_valid", 32'(bus.out_valid), 1);
      chk("in_ready_busy", 32'(bus.in_ready), 0);
      chk("out_data", 32'(bus.out_data), 32'(vecs[v].exp[beat]));
      chk("out_idx", 32'(bus.out_idx), 32'(beat));
      chk("out_err", 32'(bus.out_err), 32'(vecs[v].err[beat]));
      chk("out_last", 32'(bus.out_last), 32'(beat == 8));
      chk("frame_err_run", 32'(bus.frame_err), 32'(fe));
`ifdef GATHER_PERM_CHECK_EN
      chk("perm_err", 32'(bus.perm_err), 32'(vecs[v].perm));
`endif
      if (bus.out_ready) begin
        fe = fe | vecs[v].err[beat];
        beat++;
      end
      if (beat == 9) break;
      @(posedge clk);
      #1 c++;
      bus.out_ready = !bp || (c % 3 == 0);
    end
    chk("beats", 32'(beat), 9);
    @(negedge clk);
    chk("done_pulse", 32'(bus.done), 1);
    chk("done_valid", 32'(bus.out_valid), 0);
    chk("frame_err_done", 32'(bus.frame_err), 32'(|vecs[v].err));
    @(negedge clk);
    chk("done_once", 32'(bus.done), 0);
    chk("in_ready_back", 32'(bus.in_ready), 1);
    chk("frame_err_hold", 32'(bus.frame_err), 32'(|vecs[v].err));
  endtask
  initial begin
    vecs[0] = '{'{10,20,30,40,50,60,70,80,90}, '{0,1,2,3,4,5,6,7,8},
                '{10,20,30,40,50,60,70,80,90}, 9'h000, 1'b0};
    vecs[1] = '{'{5,3,8,1,9,2,7,4,6}, '{3,5,1,7,0,8,6,2,4},
                '{1,2,3,4,5,6,7,8,9}, 9'h000, 1'b0};
    vecs[2] = '{'{10,20,30,40,50,60,70,80,90}, '{0,1,2,15,4,5,6,7,8},
                '{10,20,30,0,50,60,70,80,90}, 9'h008, 1'b1};
    vecs[3] = '{'{5,3,8,1,9,2,7,4,6}, '{0,1,1,3,4,5,6,7,9},
                '{5,3,3,1,9,2,7,4,0}, 9'h100, 1'b1};
    vecs[4] = '{'{10,20,30,40,50,60,70,80,90}, '{0,1,1,3,4,5,6,7,8},
                '{10,20,20,40,50,60,70,80,90}, 9'h000, 1'b1};
    bus.in_valid = 1'b0;
    bus.abort = 1'b0;
    bus.out_ready = 1'b0;
    bus.arr_flat = '0;
    bus.ptr_flat = '0;
    #2;
    chk("rst_in_ready", 32'(bus.in_ready), 0);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_data", 32'(bus.out_data), 0);
    chk("rst_out_idx", 32'(bus.out_idx), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_frame_err", 32'(bus.frame_err), 0);
`ifdef GATHER_PERM_CHECK_EN
    chk("rst_perm_err", 32'(bus.perm_err), 0);
`endif
    #10 rst_n = 1'b1;
    for (int v = 0; v < 5; v++) do_frame(v, 1'b0);
    do_frame(1, 1'b1);
    // abort at idx 4 of a frame whose beat 3 is out of range
    @(negedge clk);
    load(2);
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 bus.abort = 1'b1;
    @(negedge clk);
    chk("abort_idx", 32'(bus.out_idx), 4);
    chk("abort_valid_pre", 32'(bus.out_valid), 1);
    @(posedge clk);
    #1 bus.abort = 1'b0;
    @(negedge clk);
    chk("abort_valid", 32'(bus.out_valid), 0);
    chk("abort_in_ready", 32'(bus.in_ready), 1);
    chk("abort_no_done", 32'(bus.done), 0);
    chk("abort_frame_err", 32'(bus.frame_err), 1);
    @(negedge clk);
    chk("abort_no_done2", 32'(bus.done), 0);
    // asynchronous reset mid-frame
    load(2);
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    chk("pre_rst_frame_err", 32'(bus.frame_err), 1);
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(bus.out_valid), 0);
    chk("arst_in_ready", 32'(bus.in_ready), 0);
    chk("arst_out_data", 32'(bus.out_data), 0);
    chk("arst_out_idx", 32'(bus.out_idx), 0);
    chk("arst_out_last", 32'(bus.out_last), 0);
    chk("arst_frame_err", 32'(bus.frame_err), 0);
    chk("arst_done", 32'(bus.done), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("arst_in_ready_back", 32'(bus.in_ready), 1);
    chk("arst_no_done", 32'(bus.done), 0);
    do_frame(0, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
